// File: rtl/drive_ctrl.sv
// Line-following differential drive controller: sensor FSM, ramped PWM duties, per-channel and battery overcurrent protection.
// Optional active braking in STOP is enabled by defining DRIVE_BRAKE_EN.
module drive_ctrl #(
  parameter int NCH       = 2,
  parameter int PWM_W     = 8,
  parameter int DUTY_FWD  = 200,
  parameter int DUTY_TURN = 60,
  parameter int RAMP_STEP = 8,
  parameter int TICK_DIV  = 256,
  parameter int LOST_CYC  = 50000,
  parameter int RETRY_CYC = 100000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             L,
  input  logic             C,
  input  logic             R,
  input  logic [NCH-1:0]   Over,
  input  logic             OverBat,
  output logic [NCH-1:0]   En,
  output logic [2*NCH-1:0] Motor,
  output logic [NCH-1:0]   Fault,
  output logic [2:0]       State
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = (LOST_CYC > 1) ? $clog2(LOST_CYC + 1) : 1;
  localparam int CW = (RETRY_CYC > 1) ? $clog2(RETRY_CYC + 1) : 1;

  localparam logic [PWM_W-1:0] W_FWD  = PWM_W'(DUTY_FWD);
  localparam logic [PWM_W-1:0] W_TURN = PWM_W'(DUTY_TURN);
  localparam logic [PWM_W-1:0] W_STEP = PWM_W'(RAMP_STEP);

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_FWD    = 3'd1,
    ST_LEFT   = 3'd2,
    ST_RIGHT  = 3'd3,
    ST_SEARCH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TURN_NONE  = 2'd0,
    TURN_LEFT  = 2'd1,
    TURN_RIGHT = 2'd2
  } turn_t;

  state_t                  r_state, w_state_nxt;
  turn_t                   r_turn, w_turn_nxt;
  logic [LW-1:0]           r_lost;
  logic [PWM_W-1:0]        r_cnt;
  logic [TW-1:0]           r_tick;
  logic                    w_tick;
  logic                    w_left_slow, w_right_slow;
  logic [NCH-1:0][PWM_W-1:0] r_duty, w_duty_nxt, w_target;
  logic [NCH-1:0][CW-1:0]  r_cool, w_cool_nxt;
  logic [NCH-1:0]          r_fault, w_fault_nxt;
  logic [NCH-1:0]          r_en, w_en_nxt;
  logic [NCH-1:0]          r_brake, w_brake_nxt;

  // Movement FSM next state; the turn memory lets SEARCH keep the last turn's targets.
  always_comb begin
    w_state_nxt = r_state;
    w_turn_nxt  = r_turn;
    if (C || (L && R)) begin
      w_state_nxt = ST_FWD;
    end else if (L) begin
      w_state_nxt = ST_LEFT;
    end else if (R) begin
      w_state_nxt = ST_RIGHT;
    end else begin
      case (r_state)
        ST_FWD, ST_LEFT, ST_RIGHT: w_state_nxt = ST_SEARCH;
        ST_SEARCH: begin
          if (r_lost == LW'(LOST_CYC - 1)) w_state_nxt = ST_STOP;
        end
        default: w_state_nxt = r_state;
      endcase
    end
    if (w_state_nxt == ST_LEFT)  w_turn_nxt = TURN_LEFT;
    if (w_state_nxt == ST_RIGHT) w_turn_nxt = TURN_RIGHT;
  end

  assign w_tick = (r_tick == TW'(TICK_DIV - 1));

  always_comb begin
    w_left_slow  = (r_state == ST_LEFT)  || ((r_state == ST_SEARCH) && (r_turn == TURN_LEFT));
    w_right_slow = (r_state == ST_RIGHT) || ((r_state == ST_SEARCH) && (r_turn == TURN_RIGHT));
    w_target = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r_state == ST_STOP) begin
        w_target[i] = '0;
      end else if ((i % 2) == 0) begin
        w_target[i] = w_left_slow ? W_TURN : W_FWD;
      end else begin
        w_target[i] = w_right_slow ? W_TURN : W_FWD;
      end
    end
  end

  // Per-channel fault, duty ramp, brake and PWM enable.
  always_comb begin
    w_fault_nxt = r_fault;
    w_cool_nxt  = r_cool;
    w_duty_nxt  = r_duty;
    w_brake_nxt = '0;
    w_en_nxt    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (Over[i]) begin
        w_fault_nxt[i] = 1'b1;
        w_cool_nxt[i]  = CW'(RETRY_CYC);
      end else if (r_fault[i]) begin
        if (r_cool[i] <= CW'(1)) begin
          w_fault_nxt[i] = 1'b0;
          w_cool_nxt[i]  = '0;
        end else begin
          w_cool_nxt[i]  = r_cool[i] - 1'b1;
        end
      end

      // A channel that was faulted on this edge still holds duty 0, so it restarts from 0.
      if (OverBat || Over[i] || r_fault[i]) begin
        w_duty_nxt[i] = '0;
      end else if (w_tick) begin
        if (r_duty[i] < w_target[i]) begin
          w_duty_nxt[i] = ((w_target[i] - r_duty[i]) > W_STEP) ? (r_duty[i] + W_STEP) : w_target[i];
        end else if (r_duty[i] > w_target[i]) begin
          w_duty_nxt[i] = ((r_duty[i] - w_target[i]) > W_STEP) ? (r_duty[i] - W_STEP) : w_target[i];
        end
      end

`ifdef DRIVE_BRAKE_EN
      w_brake_nxt[i] = (w_state_nxt == ST_STOP) && (w_duty_nxt[i] == '0) &&
                       !w_fault_nxt[i] && !OverBat;
`else
      w_brake_nxt[i] = 1'b0;
`endif

      w_en_nxt[i] = !OverBat && !Over[i] && (w_brake_nxt[i] || (r_cnt < r_duty[i]));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_STOP;
      r_turn  <= TURN_NONE;
      r_lost  <= '0;
      r_cnt   <= '0;
      r_tick  <= '0;
      r_duty  <= '0;
      r_cool  <= '0;
      r_fault <= '0;
      r_en    <= '0;
      r_brake <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_turn  <= w_turn_nxt;
      r_lost  <= ((r_state == ST_SEARCH) && (w_state_nxt == ST_SEARCH)) ? (r_lost + 1'b1) : '0;
      r_cnt   <= r_cnt + 1'b1;
      r_tick  <= w_tick ? '0 : (r_tick + 1'b1);
      r_duty  <= w_duty_nxt;
      r_cool  <= w_cool_nxt;
      r_fault <= w_fault_nxt;
      r_en    <= w_en_nxt;
      r_brake <= w_brake_nxt;
    end
  end

  always_comb begin
    Motor = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r_brake[i])            Motor[2*i +: 2] = 2'b11;
      else if (r_duty[i] != '0)  Motor[2*i +: 2] = 2'b10;
      else                       Motor[2*i +: 2] = 2'b00;
    end
  end

  assign En    = r_en;
  assign Fault = r_fault;
  assign State = r_state;

endmodule

// File: tb/tb_drive_ctrl.sv
// Directed bench for drive_ctrl with small parameters: movement table, PWM ratio, faults, battery trip, reset.
module tb_drive_ctrl;

  localparam int NCH = 2;
`ifdef DRIVE_BRAKE_EN
  localparam bit BRAKE = 1'b1;
`else
  localparam bit BRAKE = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST, L, C, R, OverBat;
  logic [NCH-1:0]   Over;
  logic [NCH-1:0]   En;
  logic [2*NCH-1:0] Motor;
  logic [NCH-1:0]   Fault;
  logic [2:0]       State;

  int n_chk  = 0;
  int n_fail = 0;

  drive_ctrl #(
    .NCH(NCH), .PWM_W(4), .DUTY_FWD(12), .DUTY_TURN(4), .RAMP_STEP(4),
    .TICK_DIV(1), .LOST_CYC(5), .RETRY_CYC(10)
  ) dut (
    .CLK(CLK), .RST(RST), .L(L), .C(C), .R(R), .Over(Over), .OverBat(OverBat),
    .En(En), .Motor(Motor), .Fault(Fault), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic     l, c, r;
    logic [2:0] st;
    int       d0, d1;
    bit       chk_en;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [1:0] mpair(input int d, input logic [2:0] st);
    if (d > 0) return 2'b10;
    if (BRAKE && st == 3'd0) return 2'b11;
    return 2'b00;
  endfunction

  initial begin
    int cnt0, cnt1;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 3'd1, 0, 0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd1, 4, 4, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 3'd1, 8, 8, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'd1, 12, 12, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'd1, 12, 12, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd2, 12, 12, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8, 12, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd2, 4, 12, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd2, 4, 12, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'd4, 4, 12, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 3'd4, 4, 12, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 3'd4, 4, 12, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd4, 4, 12, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd4, 4, 12, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 3'd0, 4, 12, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 0, 8, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 3'd0, 0, 4, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 3'd3, 0, 0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 3'd3, 4, 4, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 3'd3, 8, 4, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 1'b1, 3'd3, 12, 4, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 1'b1, 3'd1, 12, 4, 1'b0};
    tbl[24] = '{1'b1, 1'b0, 1'b1, 3'd1, 12, 8, 1'b0};
    tbl[25] = '{1'b1, 1'b0, 1'b1, 3'd1, 12, 12, 1'b0};

    RST = 1'b1; L = 1'b0; C = 1'b0; R = 1'b0; Over = '0; OverBat = 1'b0;
    step();
    step();
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_en", 32'(En), 32'd0);
    chk("reset_motor", 32'(Motor), 32'd0);
    chk("reset_fault", 32'(Fault), 32'd0);
    chk("reset_duty0", 32'(dut.r_duty[0]), 32'd0);

    RST = 1'b0;
    for (int i = 0; i < 26; i++) begin
      L = tbl[i].l; C = tbl[i].c; R = tbl[i].r;
      step();
      chk($sformatf("tbl%0d_state", i), 32'(State), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_duty0", i), 32'(dut.r_duty[0]), 32'(tbl[i].d0));
      chk($sformatf("tbl%0d_duty1", i), 32'(dut.r_duty[1]), 32'(tbl[i].d1));
      chk($sformatf("tbl%0d_motor", i), 32'(Motor),
          32'({mpair(tbl[i].d1, tbl[i].st), mpair(tbl[i].d0, tbl[i].st)}));
      if (tbl[i].chk_en)
        chk($sformatf("tbl%0d_en", i), 32'(En), (BRAKE && tbl[i].st == 3'd0) ? 32'd3 : 32'd0);
    end

    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      cnt0 += int'(En[0]);
      cnt1 += int'(En[1]);
    end
    chk("pwm_ratio_ch0", 32'(cnt0), 32'd12);
    chk("pwm_ratio_ch1", 32'(cnt1), 32'd12);

    Over = 2'b01;
    step();
    Over = 2'b00;
    chk("ovr_fault", 32'(Fault), 32'd1);
    chk("ovr_en0", 32'(En[0]), 32'd0);
    chk("ovr_motor0", 32'(Motor[1:0]), 32'd0);
    chk("ovr_duty0", 32'(dut.r_duty[0]), 32'd0);
    chk("ovr_duty1", 32'(dut.r_duty[1]), 32'd12);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("cool%0d_fault", k), 32'(Fault), 32'd1);
      chk($sformatf("cool%0d_en0", k), 32'(En[0]), 32'd0);
      chk($sformatf("cool%0d_duty1", k), 32'(dut.r_duty[1]), 32'd12);
    end
    step();
    chk("clear_fault", 32'(Fault), 32'd0);
    chk("clear_duty0", 32'(dut.r_duty[0]), 32'd0);
    step();
    chk("restart_duty0", 32'(dut.r_duty[0]), 32'd4);
    chk("restart_motor0", 32'(Motor[1:0]), 32'd2);
    step();
    chk("restart2_duty0", 32'(dut.r_duty[0]), 32'd8);

    Over = 2'b10;
    step();
    Over = 2'b00;
    for (int k = 0; k < 4; k++) step();
    chk("reload_pre_fault", 32'(Fault), 32'd2);
    Over = 2'b10;
    step();
    Over = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("reload%0d_fault", k), 32'(Fault), 32'd2);
    end
    step();
    chk("reload_clear", 32'(Fault), 32'd0);
    for (int k = 0; k < 4; k++) step();
    chk("settle_duty0", 32'(dut.r_duty[0]), 32'd12);
    chk("settle_duty1", 32'(dut.r_duty[1]), 32'd12);

    OverBat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bat%0d_en", k), 32'(En), 32'd0);
      chk($sformatf("bat%0d_motor", k), 32'(Motor), 32'd0);
      chk($sformatf("bat%0d_duty0", k), 32'(dut.r_duty[0]), 32'd0);
      chk($sformatf("bat%0d_duty1", k), 32'(dut.r_duty[1]), 32'd0);
    end
    OverBat = 1'b0;
    step();
    chk("batrel_duty0", 32'(dut.r_duty[0]), 32'd4);
    chk("batrel_duty1", 32'(dut.r_duty[1]), 32'd4);
    chk("batrel_en", 32'(En), 32'd0);
    step();
    chk("batrel2_duty1", 32'(dut.r_duty[1]), 32'd8);

    OverBat = 1'b1; Over = 2'b01;
    step();
    OverBat = 1'b0; Over = 2'b00;
    chk("both_fault", 32'(Fault), 32'd1);
    chk("both_en", 32'(En), 32'd0);
    chk("both_motor", 32'(Motor), 32'd0);
    chk("both_duty1", 32'(dut.r_duty[1]), 32'd0);
    step();
    chk("both_after_duty0", 32'(dut.r_duty[0]), 32'd0);
    chk("both_after_duty1", 32'(dut.r_duty[1]), 32'd4);

    step();
    RST = 1'b1;
    step();
    chk("rstflt_fault", 32'(Fault), 32'd0);
    chk("rstflt_state", 32'(State), 32'd0);
    chk("rstflt_en", 32'(En), 32'd0);
    chk("rstflt_motor", 32'(Motor), 32'd0);
    chk("rstflt_duty1", 32'(dut.r_duty[1]), 32'd0);
    RST = 1'b0; L = 1'b0; C = 1'b0; R = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("post%0d_fault", k), 32'(Fault), 32'd0);
      chk($sformatf("post%0d_state", k), 32'(State), 32'd0);
      chk($sformatf("post%0d_motor", k), 32'(Motor), BRAKE ? 32'hF : 32'd0);
      chk($sformatf("post%0d_en", k), 32'(En), BRAKE ? 32'd3 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
